// File: rtl/ahb3_mem_slave.sv
// -----------------------------------------------------------------------------
// ahb3_mem_slave
//
// Parametrised AHB3-Lite on-chip RAM target. Address and data phases are
// fully pipelined: a new transfer may be accepted in the same cycle that the
// previous data phase completes. Each OKAY data phase can be stretched by a
// fixed number of wait states. Illegal transfers (out of range, oversize,
// misaligned) get the two-cycle ERROR response and never touch the memory.
// A read accepted on the edge where a write to the same word commits sees
// the freshly written lanes.
//
// Ports
//   hclk        bus clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   hsel        slave select
//   haddr       byte address (address phase)
//   hwdata      write data (data phase)
//   hrdata      read data, zero outside read data phases
//   hwrite      1 = write, 0 = read
//   hsize       0 = byte, 1 = half, 2 = word, 3 = dword
//   hburst      burst type, ignored (each beat decoded on its own)
//   hprot       protection attributes, ignored
//   htrans      IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   hmastlock   locked transfer, ignored
//   hready      bus-level ready (previous data phase finished)
//   hreadyout   slave ready
//   hresp       0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module ahb3_mem_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [HADDR_SIZE-1:0] haddr,
    input  logic [HDATA_SIZE-1:0] hwdata,
    output logic [HDATA_SIZE-1:0] hrdata,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    input  logic                  hmastlock,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int NBYTES = HDATA_SIZE / 8;
    localparam int LANE_W = $clog2(NBYTES);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                state_q,  state_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [LANE_W-1:0]     lane_q,   lane_d;
    logic [2:0]            size_q,   size_d;
    logic                  write_q,  write_d;
    logic [HDATA_SIZE-1:0] hrdata_q, hrdata_d;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    // Sideband attributes have no effect on a plain RAM target.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic                  slave_ready;
    logic                  accept;
    logic                  req_err;
    logic [IDX_W-1:0]      req_idx;
    logic [HADDR_SIZE-1:0] word_addr;
    logic [HADDR_SIZE-1:0] align_mask;

    // Only IDLE, DATA and ERR2 drive hreadyout high; gating acceptance on it
    // keeps the FSM safe even if hready is not looped back from this slave.
    assign slave_ready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign accept      = hsel && hready && htrans[1] && slave_ready;

    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned and no latch forms.
    always_comb begin
        word_addr  = haddr >> LANE_W;
        align_mask = HADDR_SIZE'((32'd1 << hsize) - 32'd1);
        req_idx    = haddr[LANE_W +: IDX_W];
        req_err    = (word_addr >= HADDR_SIZE'(MEM_DEPTH))
                   || ((32'd1 << hsize) > 32'(NBYTES))
                   || ((haddr & align_mask) != '0);
    end

    // ------------------------------------------------------------------
    // Write lanes of the transfer currently in its data phase
    // ------------------------------------------------------------------
    logic [NBYTES-1:0] wr_be;
    logic              wr_en;

    always_comb begin
        wr_be = '0;
        for (int i = 0; i < NBYTES; i++) begin
            wr_be[i] = (i >= int'(lane_q)) && (i < int'(lane_q) + (1 << size_q));
        end
    end

    // A write in DATA commits at the edge that ends DATA, unless that edge
    // is a reset edge, which discards the pending write.
    assign wr_en = (state_q == ST_DATA) && write_q && !rst;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic             rd_enter;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        size_d   = size_q;
        write_d  = write_q;
        rd_enter = 1'b0;
        rd_idx   = idx_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_DATA;
                    rd_enter = !write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // DATA and ERR2 accept a new address phase exactly like IDLE.
        if (accept) begin
            idx_d   = req_idx;
            lane_d  = haddr[LANE_W-1:0];
            size_d  = hsize;
            write_d = hwrite;
            if (req_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end else begin
                state_d  = ST_DATA;
                rd_enter = !hwrite;
                rd_idx   = req_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data with forwarding from a write committing on the same edge
    // ------------------------------------------------------------------
    logic [HDATA_SIZE-1:0] rd_word;

    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_en && wr_be[i] && (idx_q == rd_idx)) begin
                rd_word[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
        hrdata_d = rd_enter ? rd_word : '0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge hclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive rst and it maps
    // onto plain RAM rather than a huge bank of resettable flops.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hreadyout = slave_ready;
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb3_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb3_mem_slave
//
// Two slaves share clock and reset: u0 with no wait states, u1 with three.
// Each slave's hready is its own hreadyout (single-slave bus). Stimulus tasks
// drive address phases and push the expected data-phase response into a
// queue; a monitor follows the bus protocol, pops an entry whenever a data
// phase completes, and checks idle cycles against the quiescent outputs.
// -----------------------------------------------------------------------------
module tb_ahb3_mem_slave;

    localparam int WS1 = 3;

    typedef struct {
        int          inst;
        string       name;
        bit          err;
        bit          is_read;
        logic [31:0] rdata;
        int          stall;
    } exp_t;

    logic        hclk;
    logic        rst;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [3:0]  hprot     [2];
    logic [1:0]  htrans    [2];
    logic        hmastlock [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    ahb3_mem_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .rst(rst), .hsel(hsel[0]), .haddr(haddr[0]), .hwdata(hwdata[0]),
        .hrdata(hrdata[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]),
        .hprot(hprot[0]), .htrans(htrans[0]), .hmastlock(hmastlock[0]), .hready(hready[0]),
        .hreadyout(hreadyout[0]), .hresp(hresp[0])
    );

    ahb3_mem_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(WS1)) u1 (
        .hclk(hclk), .rst(rst), .hsel(hsel[1]), .haddr(haddr[1]), .hwdata(hwdata[1]),
        .hrdata(hrdata[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]),
        .hprot(hprot[1]), .htrans(htrans[1]), .hmastlock(hmastlock[1]), .hready(hready[1]),
        .hreadyout(hreadyout[1]), .hresp(hresp[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the bus", name);
    endtask

    // Issue one address phase; returns just after the accepting edge with the
    // write data (if any) driven for the data phase.
    task automatic xfer(input int g, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit err, input logic [31:0] rd_exp,
                        input string nm, input bit track);
        exp_t e;
        bit   rdy;
        bit   accepted;
        if (track) begin
            e.inst    = g;
            e.name    = nm;
            e.err     = err;
            e.is_read = !wr;
            e.rdata   = rd_exp;
            e.stall   = err ? 1 : ((g == 0) ? 0 : WS1);
            exp_q.push_back(e);
        end
        hsel[g]   = 1'b1;
        htrans[g] = 2'b10;
        haddr[g]  = a;
        hwrite[g] = wr;
        hsize[g]  = sz;
        accepted  = 1'b0;
        for (int n = 0; n < 64 && !accepted; n++) begin
            @(negedge hclk);
            rdy = hready[g];
            @(posedge hclk);
            accepted = rdy;
        end
        #1;
        if (!accepted) timeout_fail({nm, "_accept"});
        hsel[g]   = 1'b0;
        htrans[g] = 2'b00;
        if (wr) hwdata[g] = wd;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge hclk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        repeat (2) @(posedge hclk);
        #1;
    endtask

    // Protocol-following monitor: decides per cycle whether each slave is in
    // a data phase, and compares completions against the scoreboard queue.
    initial begin
        bit   in_dp [2];
        int   stall [2];
        bit   sresp [2];
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            in_dp[g] = 1'b0;
            stall[g] = 0;
            sresp[g] = 1'b0;
        end
        forever begin
            @(negedge hclk);
            if (mon_en) begin
                for (int g = 0; g < 2; g++) begin
                    if (in_dp[g]) begin
                        if (!hreadyout[g]) begin
                            stall[g]++;
                            sresp[g] |= hresp[g];
                            check($sformatf("u%0d_stall_hrdata", g), hrdata[g], 32'h0);
                        end else begin
                            if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL u%0d_unexpected_completion: got a completed data phase, expected none", g);
                            end else begin
                                e = exp_q.pop_front();
                                check({e.name, "_stall_cycles"}, stall[g], e.stall);
                                check({e.name, "_stall_hresp"}, 32'(sresp[g]), 32'(e.err));
                                check({e.name, "_hresp"}, 32'(hresp[g]), 32'(e.err));
                                check({e.name, "_hrdata"}, hrdata[g], (e.is_read && !e.err) ? e.rdata : 32'h0);
                            end
                            stall[g] = 0;
                            sresp[g] = 1'b0;
                        end
                    end else begin
                        check($sformatf("u%0d_idle_hreadyout", g), 32'(hreadyout[g]), 32'h1);
                        check($sformatf("u%0d_idle_hresp", g), 32'(hresp[g]), 32'h0);
                        check($sformatf("u%0d_idle_hrdata", g), hrdata[g], 32'h0);
                    end
                    if (rst) begin
                        in_dp[g] = 1'b0;
                        stall[g] = 0;
                        sresp[g] = 1'b0;
                    end else if (hsel[g] && hready[g] && htrans[g][1]) begin
                        in_dp[g] = 1'b1;
                    end else if (hready[g]) begin
                        in_dp[g] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            hsel[g]      = 1'b0;
            haddr[g]     = '0;
            hwdata[g]    = '0;
            hwrite[g]    = 1'b0;
            hsize[g]     = 3'd0;
            hburst[g]    = 3'd1;
            hprot[g]     = 4'b0011;
            htrans[g]    = 2'b00;
            hmastlock[g] = 1'b0;
        end
        repeat (2) @(posedge hclk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge hclk);
        #1;

        // ---- u0: zero wait states, back-to-back with forwarding ----
        xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0,        "u0_wr_10",      1);
        xfer(0, 0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF, "u0_rd_10_fwd",  1);
        xfer(0, 1, 32'h20, 3'd2, 32'h11223344, 0, 32'h0,        "u0_wr_20",      1);
        xfer(0, 1, 32'h21, 3'd0, 32'hFFFFAAFF, 0, 32'h0,        "u0_wrb_21",     1);
        xfer(0, 0, 32'h20, 3'd2, 32'h0,        0, 32'h1122AA44, "u0_rd_20_byte", 1);
        xfer(0, 1, 32'h22, 3'd1, 32'h5566FFFF, 0, 32'h0,        "u0_wrh_22",     1);
        drain();
        xfer(0, 0, 32'h20, 3'd2, 32'h0,        0, 32'h5566AA44, "u0_rd_20_half", 1);
        xfer(0, 1, 32'h3FC, 3'd2, 32'h0F0F0F0F, 0, 32'h0,       "u0_wr_last",    1);
        drain();
        xfer(0, 0, 32'h3FC, 3'd2, 32'h0,       0, 32'h0F0F0F0F, "u0_rd_last",    1);
        xfer(0, 1, 32'h0,  3'd2, 32'hCAFEF00D, 0, 32'h0,        "u0_wr_0",       1);

        // ---- u0: error responses ----
        xfer(0, 0, 32'h400, 3'd2, 32'h0,       1, 32'h0,        "u0_rd_oor",     1);
        xfer(0, 1, 32'h3,  3'd1, 32'hBEEFBEEF, 1, 32'h0,        "u0_wrh_unal",   1);
        xfer(0, 0, 32'h8,  3'd3, 32'h0,        1, 32'h0,        "u0_rd_dword",   1);
        xfer(0, 0, 32'h0,  3'd2, 32'h0,        0, 32'hCAFEF00D, "u0_rd_0_keep",  1);
        drain();

        // ---- u1: three wait states ----
        xfer(1, 1, 32'h40, 3'd2, 32'h0BADC0DE, 0, 32'h0,        "u1_wr_40",      1);
        xfer(1, 0, 32'h40, 3'd2, 32'h0,        0, 32'h0BADC0DE, "u1_rd_40",      1);
        drain();
        xfer(1, 0, 32'h400, 3'd2, 32'h0,       1, 32'h0,        "u1_rd_oor",     1);
        xfer(1, 0, 32'h40, 3'd2, 32'h0,        0, 32'h0BADC0DE, "u1_rd_40_b",    1);
        xfer(1, 1, 32'h44, 3'd2, 32'h12345678, 0, 32'h0,        "u1_wr_44",      1);
        drain();

        // ---- u1: reset in the middle of a write's wait states ----
        xfer(1, 1, 32'h44, 3'd2, 32'hFFFFFFFF, 0, 32'h0,        "u1_wr_abort",   0);
        @(posedge hclk);
        #1;
        rst = 1'b1;
        @(posedge hclk);
        #1;
        rst = 1'b0;
        @(posedge hclk);
        #1;
        xfer(1, 0, 32'h44, 3'd2, 32'h0,        0, 32'h12345678, "u1_rd_44_keep", 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
